ifid_stall_ctrl: RTL and testbench
==================================

IFID_STALL_CTRL -- requirements
Module: ifid_stall_ctrl

Interface
REQ-001 SHALL have parameter PC_W, 32, PC and address width.
REQ-002 SHALL have parameter INSTR_W, 32, instruction width.
REQ-003 SHALL have parameter STALL_MAX, 15, consecutive-stall limit for the watchdog (1..255).
REQ-004 SHALL use one clock and a synchronous, active-high reset; all state changes on posedge clk.
REQ-005 SHALL have ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous active-high reset
- stall  input  1  data-hazard stall request from hazard detection
- flush  input  1  branch/jump redirect taken in EX; squash IF/ID
- pc_next  input  PC_W  next-PC value (PC+4 or redirect target)
- instr_in  input  INSTR_W  instruction memory read data at pc
- pc  output  PC_W  fetch address register
- instructionID  output  INSTR_W  IF/ID instruction; 32'b0 is a bubble
- pcID  output  PC_W  IF/ID PC+4
- validID  output  1  IF/ID holds a real instruction
- stall_timeout  output  1  sticky watchdog flag
- stall_cycles  output  32  performance counter (see Configuration)

Function
REQ-006 SHALL implement a 3-state FSM: RUN, HOLD, SQUASH.
REQ-007 SHALL give flush priority over stall whenever both are asserted in the same cycle.
REQ-008 In any state with flush=1: pc<=pc_next, instructionID<=0, pcID<=0, validID<=0, next state SQUASH.
REQ-009 With flush=0 and stall=1: pc, instructionID, pcID, validID SHALL hold their values; next state HOLD.
REQ-010 With flush=0 and stall=0: pc<=pc_next, instructionID<=instr_in, pcID<=pc+4, validID<=(instr_in!=0); next state RUN.
REQ-011 SQUASH SHALL last exactly one cycle unless flush is reasserted; HOLD SHALL persist while stall=1.
REQ-012 Fetch-to-ID latency SHALL be one cycle; each held stall cycle adds one cycle.
REQ-013 pc+4 SHALL be computed modulo 2^PC_W; wrap from all-ones-minus-3 to 0 is legal and silent.
REQ-014 SHALL count consecutive stall cycles (flush=0, stall=1) in a counter saturating at STALL_MAX; the counter SHALL clear on any cycle without stall or with flush.
REQ-015 stall_timeout SHALL set on the cycle the counter reaches STALL_MAX and remain set until reset.
REQ-016 Deassertion of stall SHALL release the held instruction into ID on the next edge without loss or duplication.

Reset
REQ-017 On rst=1 at posedge: pc=0, instructionID=0, pcID=0, validID=0, stall_timeout=0, consecutive counter=0, stall_cycles=0, state RUN.
REQ-018 rst SHALL override stall and flush; reset asserted mid-HOLD or mid-SQUASH SHALL discard the held instruction.
REQ-019 The first fetch after reset deassertion SHALL be from address 0.

Configuration
REQ-020 With macro STALL_PERF_CNT_EN defined: stall_cycles SHALL increment by 1 on every cycle with stall=1 and flush=0, wrapping at 2^32.
REQ-021 Without STALL_PERF_CNT_EN: stall_cycles SHALL be constant 0 and no counter logic SHALL be synthesized; all other behaviour identical.

Verification
REQ-022 Reset, then 3 cycles stall=0 with pc_next=pc+4, instr_in=0x8C220004 -> pc=0x0C, instructionID=0x8C220004, pcID=0x0C, validID=1.
REQ-023 Stall held 2 cycles with instructionID=0x00430820 -> instructionID and pc unchanged both cycles; released instruction appears once after stall drops; stall_cycles=2 (STALL_PERF_CNT_EN).
REQ-024 flush=1 and stall=1 together, pc_next=0x40 -> next cycle pc=0x40, instructionID=0, validID=0, state SQUASH, stall_cycles unchanged.
REQ-025 Stall held 15 cycles (STALL_MAX=15) -> stall_timeout=1 after the 15th edge; stays 1 after stall drops; clears only on rst.
REQ-026 pc=0xFFFFFFFC, stall=0 -> pcID=0x00000000, no error; rst asserted during a 3-cycle stall -> all outputs zero next cycle, fetch resumes at 0.

Source files
------------

// File: rtl/ifid_stall_ctrl.sv
// IF/ID pipeline register with stall/flush control, stall watchdog and optional stall counter.
// Optional feature macro: STALL_PERF_CNT_EN (free-running stall-cycle performance counter).
module ifid_stall_ctrl #(
    parameter int PC_W      = 32,
    parameter int INSTR_W   = 32,
    parameter int STALL_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    pc_next,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instructionID,
    output logic [PC_W-1:0]    pcID,
    output logic               validID,
    output logic               stall_timeout,
    output logic [31:0]        stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(STALL_MAX);

    state_t     state;
    logic [7:0] stallCnt;
    logic [7:0] stallCntNext;

    // A stall entered from RUN or SQUASH is the first of a run; only HOLD continues one.
    always_comb begin
        stallCntNext = 8'd1;
        if (state == HOLD) begin
            stallCntNext = (stallCnt >= MAX_CNT) ? MAX_CNT : stallCnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pc            <= '0;
            instructionID <= '0;
            pcID          <= '0;
            validID       <= 1'b0;
            stallCnt      <= '0;
            stall_timeout <= 1'b0;
        end else if (flush) begin
            state         <= SQUASH;
            pc            <= pc_next;
            instructionID <= '0;
            pcID          <= '0;
            validID       <= 1'b0;
            stallCnt      <= '0;
        end else if (stall) begin
            state    <= HOLD;
            stallCnt <= stallCntNext;
            if (stallCntNext == MAX_CNT) begin
                stall_timeout <= 1'b1;
            end
        end else begin
            state         <= RUN;
            pc            <= pc_next;
            instructionID <= instr_in;
            pcID          <= pc + PC_W'(4);
            validID       <= (instr_in != '0);
            stallCnt      <= '0;
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && !flush) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ifid_stall_ctrl.sv
// Directed bench for ifid_stall_ctrl: abstract reference model checked every cycle plus literal pins.
module tb_ifid_stall_ctrl;

    localparam int PC_W      = 32;
    localparam int INSTR_W   = 32;
    localparam int STALL_MAX = 15;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall;
    logic               flush;
    logic [PC_W-1:0]    pc_next;
    logic [INSTR_W-1:0] instr_in;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instructionID;
    logic [PC_W-1:0]    pcID;
    logic               validID;
    logic               stall_timeout;
    logic [31:0]        stall_cycles;

    int tests = 0;
    int fails = 0;
    bit armed = 0;

    // Reference model state
    logic [31:0] mPc, mInstr, mPcId, mPerf;
    bit          mValid, mTimeout;
    int          mRun;

    ifid_stall_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .STALL_MAX(STALL_MAX)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .pc_next(pc_next), .instr_in(instr_in),
        .pc(pc), .instructionID(instructionID), .pcID(pcID), .validID(validID),
        .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (armed) begin
            check("model.pc", pc, mPc);
            check("model.instructionID", instructionID, mInstr);
            check("model.pcID", pcID, mPcId);
            check("model.validID", {31'b0, validID}, {31'b0, mValid});
            check("model.stall_timeout", {31'b0, stall_timeout}, {31'b0, mTimeout});
            check("model.stall_cycles", stall_cycles, mPerf);
        end
    end

    // One clock: apply inputs, advance the model by the specified rules, settle.
    task automatic cyc(input bit r, input bit s, input bit f,
                       input logic [31:0] pn, input logic [31:0] ins);
        rst = r; stall = s; flush = f; pc_next = pn; instr_in = ins;
        @(posedge clk);
        if (r) begin
            mPc = 0; mInstr = 0; mPcId = 0; mValid = 0; mTimeout = 0; mRun = 0; mPerf = 0;
        end else if (f) begin
            mPc = pn; mInstr = 0; mPcId = 0; mValid = 0; mRun = 0;
        end else if (s) begin
            mRun = (mRun + 1 > STALL_MAX) ? STALL_MAX : mRun + 1;
            if (mRun == STALL_MAX) mTimeout = 1;
`ifdef STALL_PERF_CNT_EN
            mPerf = mPerf + 1;
`endif
        end else begin
            mPcId = mPc + 4; mPc = pn; mInstr = ins; mValid = (ins != 0); mRun = 0;
        end
        #1;
    endtask

    task automatic run(input logic [31:0] ins);
        cyc(0, 0, 0, mPc + 32'd4, ins);
    endtask

    task automatic stl(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 32'hBAD0_0000, 32'hDEAD_0001);
    endtask

    logic [31:0] perfBase;

    initial begin
        rst = 1; stall = 0; flush = 0; pc_next = 0; instr_in = 0;
        mPc = 0; mInstr = 0; mPcId = 0; mValid = 0; mTimeout = 0; mRun = 0; mPerf = 0;
        cyc(1, 1, 1, 32'h1234, 32'h5678);
        armed = 1;
        cyc(1, 0, 0, 0, 0);
        check("reset.pc", pc, 32'h0);
        check("reset.instructionID", instructionID, 32'h0);
        check("reset.validID", {31'b0, validID}, 32'h0);
        check("reset.stall_cycles", stall_cycles, 32'h0);

        // Three straight fetches
        for (int i = 0; i < 3; i++) run(32'h8C22_0004);
        check("fetch3.pc", pc, 32'h0000_000C);
        check("fetch3.instructionID", instructionID, 32'h8C22_0004);
        check("fetch3.pcID", pcID, 32'h0000_000C);
        check("fetch3.validID", {31'b0, validID}, 32'h1);

        // Two-cycle stall, then release
        run(32'h0043_0820);
        for (int i = 0; i < 2; i++) begin
            stl(1);
            check("stall.instructionID", instructionID, 32'h0043_0820);
            check("stall.pc", pc, 32'h0000_0010);
        end
`ifdef STALL_PERF_CNT_EN
        check("stall.perf2", stall_cycles, 32'd2);
`endif
        run(32'h1111_2222);
        check("release.instructionID", instructionID, 32'h1111_2222);
        check("release.pcID", pcID, 32'h0000_0014);

        // Flush wins over stall
        perfBase = stall_cycles;
        cyc(0, 1, 1, 32'h40, 32'h9999_9999);
        check("flush.pc", pc, 32'h40);
        check("flush.instructionID", instructionID, 32'h0);
        check("flush.validID", {31'b0, validID}, 32'h0);
        check("flush.perf_unchanged", stall_cycles, perfBase);
        run(32'h2000_0001);
        check("afterflush.pcID", pcID, 32'h44);

        // Flush mid-run restarts the watchdog count
        stl(10);
        cyc(0, 0, 1, 32'h80, 0);
        stl(10);
        check("wd.cleared_by_flush", {31'b0, stall_timeout}, 32'h0);
        run(32'h3000_0003);

        // Watchdog at exactly STALL_MAX consecutive stalls, sticky until reset
        stl(14);
        check("wd.before", {31'b0, stall_timeout}, 32'h0);
        stl(1);
        check("wd.at15", {31'b0, stall_timeout}, 32'h1);
        run(32'h4000_0004);
        run(32'h4000_0005);
        check("wd.sticky", {31'b0, stall_timeout}, 32'h1);
        cyc(1, 0, 0, 0, 0);
        check("wd.reset_clears", {31'b0, stall_timeout}, 32'h0);

        // PC+4 wraps silently; zero instruction is a bubble
        cyc(0, 0, 0, 32'hFFFF_FFFC, 32'h5000_0005);
        cyc(0, 0, 0, 32'h0000_0000, 32'h0);
        check("wrap.pcID", pcID, 32'h0);
        check("bubble.validID", {31'b0, validID}, 32'h0);

        // Reset during a stall discards the held instruction
        cyc(0, 0, 0, 32'h100, 32'h6000_0006);
        stl(2);
        cyc(1, 1, 0, 32'h200, 32'h7000_0007);
        check("rststall.pc", pc, 32'h0);
        check("rststall.instructionID", instructionID, 32'h0);
        check("rststall.validID", {31'b0, validID}, 32'h0);
        check("rststall.stall_cycles", stall_cycles, 32'h0);
        run(32'h8000_0008);
        check("resume.pcID", pcID, 32'h4);
        check("resume.pc", pc, 32'h4);
        run(32'h8000_0009);

        @(negedge clk);
        #1;
        armed = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
